stim_fifo: RTL and testbench



---
 rtl/stim_fifo_if.sv | 27 ++
 rtl/stim_fifo.sv | 82 ++++++++
 tb/tb_stim_fifo.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/stim_fifo_if.sv
// Producer/consumer bundle for stim_fifo: write port, FWFT read port and status flags.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface stim_fifo_if #(
    parameter int WIDTH = 9,
    parameter int AW    = 5
);
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             rd_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;
    logic             clr_flags;

    modport slave (
        input  wr_en, wr_data, rd_ready, clr_flags,
        output full, rd_valid, rd_data, count, overflow, underflow
    );

    modport master (
        output wr_en, wr_data, rd_ready, clr_flags,
        input  full, rd_valid, rd_data, count, overflow, underflow
    );
endinterface

// File: rtl/stim_fifo.sv
// First-word-fall-through FIFO feeding the 9-bit consumer datapath, with sticky
// overflow/underflow flags for regression checking.
module stim_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    stim_fifo_if.slave    bus
);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             ovf_q;
    logic             unf_q;
    logic             is_full;
    logic             is_valid;
    logic             wr_fire;
    logic             rd_fire;

    // Status comes only from the registered count, so no input reaches an output combinationally.
    assign is_full  = (cnt == DEPTH_CNT);
    assign is_valid = (cnt != '0);
    assign wr_fire  = bus.wr_en && !is_full;
    assign rd_fire  = bus.rd_ready && is_valid;

    assign bus.full      = is_full;
    assign bus.rd_valid  = is_valid;
    assign bus.rd_data   = mem[rd_ptr];
    assign bus.count     = cnt;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data_w();
        end
    end

    function automatic logic [WIDTH-1:0] wr_data_w();
        return bus.wr_data;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_fire, rd_fire})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
            // A fresh error in the same cycle as clr_flags must survive the clear.
            if (bus.wr_en && is_full) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_flags) begin
                ovf_q <= 1'b0;
            end
            if (bus.rd_ready && !is_valid) begin
                unf_q <= 1'b1;
            end else if (bus.clr_flags) begin
                unf_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stim_fifo.sv
// Directed self-checking bench for stim_fifo: reset, fill/drain, overflow,
// wrap-around streaming, underflow/clear race and mid-operation reset.
module tb_stim_fifo;
    localparam int WIDTH = 9;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;

    stim_fifo_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    stim_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;
        bus.clr_flags = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        checks++; if (bus.count !== 6'd0) $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); else passes++;
        checks++; if (bus.rd_valid !== 1'b0) $display("[TB] FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); else passes++;
        checks++; if (bus.full !== 1'b0) $display("[TB] FAIL reset_full: got %b expected 0", bus.full); else passes++;
        checks++; if (bus.overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", bus.overflow); else passes++;
        checks++; if (bus.underflow !== 1'b0) $display("[TB] FAIL reset_underflow: got %b expected 0", bus.underflow); else passes++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 32; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 9'(i);
            step();
            checks++; if (bus.count !== 6'(i + 1)) $display("[TB] FAIL fill_count[%0d]: got %0d expected %0d", i, bus.count, i + 1); else passes++;
        end
        bus.wr_en = 1'b0;
        checks++; if (bus.full !== 1'b1) $display("[TB] FAIL fill_full: got %b expected 1", bus.full); else passes++;
        checks++; if (bus.rd_data !== 9'h000) $display("[TB] FAIL fill_head: got %h expected 000", bus.rd_data); else passes++;
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 9'(i)) $display("[TB] FAIL drain_data[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, bus.rd_valid, bus.rd_data, 9'(i)); else passes++;
            step();
        end
        bus.rd_ready = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0) $display("[TB] FAIL drain_empty: got %b expected 0", bus.rd_valid); else passes++;
        checks++; if (bus.count !== 6'd0) $display("[TB] FAIL drain_count: got %0d expected 0", bus.count); else passes++;
        checks++; if (bus.underflow !== 1'b0) $display("[TB] FAIL drain_no_underflow: got %b expected 0", bus.underflow); else passes++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 32; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 9'(i);
            step();
        end
        bus.wr_data  = 9'h1FF;
        bus.rd_ready = 1'b1;
        step();
        bus.wr_en    = 1'b0;
        bus.rd_ready = 1'b0;
        checks++; if (bus.overflow !== 1'b1) $display("[TB] FAIL ovf_set: got %b expected 1", bus.overflow); else passes++;
        checks++; if (bus.count !== 6'd31) $display("[TB] FAIL ovf_count: got %0d expected 31", bus.count); else passes++;
        checks++; if (bus.rd_data !== 9'h001) $display("[TB] FAIL ovf_head: got %h expected 001", bus.rd_data); else passes++;
        bus.clr_flags = 1'b1;
        step();
        bus.clr_flags = 1'b0;
        checks++; if (bus.overflow !== 1'b0) $display("[TB] FAIL ovf_clear: got %b expected 0", bus.overflow); else passes++;
        bus.rd_ready = 1'b1;
        for (int i = 1; i < 32; i++) begin
            checks++; if (bus.rd_data !== 9'(i)) $display("[TB] FAIL ovf_drain[%0d]: got %h expected %h", i, bus.rd_data, 9'(i)); else passes++;
            step();
        end
        bus.rd_ready = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0) $display("[TB] FAIL ovf_dropped: got valid=%b expected 0", bus.rd_valid); else passes++;
    endtask

    task automatic test_wrap();
        bus.wr_en    = 1'b1;
        bus.wr_data  = 9'h100;
        bus.rd_ready = 1'b0;
        step();
        for (int i = 1; i < 48; i++) begin
            bus.wr_data  = 9'(9'h100 + i);
            bus.rd_ready = 1'b1;
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 9'(9'h100 + i - 1)) $display("[TB] FAIL wrap_data[%0d]: got valid=%b data=%h expected valid=1 data=%h", i - 1, bus.rd_valid, bus.rd_data, 9'(9'h100 + i - 1)); else passes++;
            checks++; if (bus.count !== 6'd1) $display("[TB] FAIL wrap_count[%0d]: got %0d expected 1", i, bus.count); else passes++;
            step();
        end
        bus.wr_en = 1'b0;
        checks++; if (bus.rd_data !== 9'h12F) $display("[TB] FAIL wrap_last: got %h expected 12f", bus.rd_data); else passes++;
        step();
        bus.rd_ready = 1'b0;
        checks++; if (bus.count !== 6'd0) $display("[TB] FAIL wrap_empty: got %0d expected 0", bus.count); else passes++;
        checks++; if (bus.underflow !== 1'b0) $display("[TB] FAIL wrap_no_underflow: got %b expected 0", bus.underflow); else passes++;
    endtask

    task automatic test_underflow_clear();
        bus.rd_ready  = 1'b1;
        bus.clr_flags = 1'b1;
        step();
        checks++; if (bus.underflow !== 1'b1) $display("[TB] FAIL unf_set_wins: got %b expected 1", bus.underflow); else passes++;
        checks++; if (bus.count !== 6'd0) $display("[TB] FAIL unf_count: got %0d expected 0", bus.count); else passes++;
        bus.rd_ready = 1'b0;
        step();
        bus.clr_flags = 1'b0;
        checks++; if (bus.underflow !== 1'b0) $display("[TB] FAIL unf_clear: got %b expected 0", bus.underflow); else passes++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 9'(9'h050 + i);
            step();
        end
        bus.wr_en = 1'b0;
        checks++; if (bus.count !== 6'd10) $display("[TB] FAIL mid_fill: got %0d expected 10", bus.count); else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.count !== 6'd0) $display("[TB] FAIL mid_rst_count: got %0d expected 0", bus.count); else passes++;
        checks++; if (bus.rd_valid !== 1'b0) $display("[TB] FAIL mid_rst_valid: got %b expected 0", bus.rd_valid); else passes++;
        rst_n = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 9'h0AA;
        step();
        bus.wr_en = 1'b0;
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 9'h0AA) $display("[TB] FAIL mid_first_write: got valid=%b data=%h expected valid=1 data=0aa", bus.rd_valid, bus.rd_data); else passes++;
        checks++; if (bus.count !== 6'd1) $display("[TB] FAIL mid_count: got %0d expected 1", bus.count); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_wrap();
        test_underflow_clear();
        test_reset_mid();
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
